dequantize: RTL and testbench

Expands Nquant-bit two's-complement codes, as produced by the requantizer, back to the 18-bit sample width. Each code is sign-extended, then shifted left one bit per clock by 18−Nquant positions, reusing the requantizer's serial-shift architecture. The block sits on the reconstruction path and has a one-entry holding register, so a single sample can be accepted while another is in flight.

---
 rtl/dequant_pkg.sv | 24 ++
 rtl/dequant_signext.sv | 27 ++
 rtl/dequantize.sv | 103 ++++++++++
 tb/tb_dequantize.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dequant_pkg.sv
// Shared constants, FSM state encoding and the decoded-sample record
// used by the dequantizer and its sign-extension front end.
package dequant_pkg;

   localparam int unsigned DATA_W = 18;
   localparam int unsigned NQ_W   = 5;

   // Valid Nquant range; anything outside is treated as full width.
   localparam logic [NQ_W-1:0] NQ_MIN = 5'd1;
   localparam logic [NQ_W-1:0] NQ_MAX = 5'd18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Sign-extended code and its remaining left-shift count.
   typedef struct packed {
      logic [DATA_W-1:0] v;
      logic [NQ_W-1:0]   s;
   } sample_t;

endpackage

// File: rtl/dequant_signext.sv
// Combinational front end: clamps Nquant, derives the shift count and
// sign-extends the right-aligned code to the full sample width.
module dequant_signext
   import dequant_pkg::*;
(
   input  logic [NQ_W-1:0]   Nquant,
   input  logic [DATA_W-1:0] datain,
   output sample_t           sample
);

   logic [NQ_W-1:0]   nq;
   logic [NQ_W-1:0]   s;
   logic [DATA_W-1:0] aligned;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      nq = Nquant;
      if (Nquant < NQ_MIN || Nquant > NQ_MAX) nq = NQ_MAX;
      s = NQ_MAX - nq;
      // Park the code's sign bit at the MSB, then arithmetic-shift back.
      aligned  = datain << s;
      sample.v = $signed(aligned) >>> s;
      sample.s = s;
   end

endmodule

// File: rtl/dequantize.sv
// Serial-shift dequantizer: sign-extended code is shifted left one bit
// per clock, with a one-entry hold register and a sticky overrun flag.
module dequantize
   import dequant_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [NQ_W-1:0]   Nquant,
   input  logic [DATA_W-1:0] datain,
   input  logic              endatain,
   output logic [DATA_W-1:0] dataout,
   output logic              dataready,
   output logic              busy,
   output logic              overrun
);

   state_t            state, next_state;
   sample_t           cur, src, hold;
   logic              hold_valid;
   logic [DATA_W-1:0] sr;
   logic [NQ_W-1:0]   cnt, shamt;
   logic              load_hold, load_new, load, hold_cap, drop;

   dequant_signext u_signext (
      .Nquant (Nquant),
      .datain (datain),
      .sample (cur)
   );

   // State register.
   // NOTE: sequential state is written with non-blocking assignments so
   // every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (endatain) next_state = (cur.s == '0) ? DONE : SHIFT;
         SHIFT:   if (cnt == shamt - NQ_W'(1)) next_state = DONE;
         DONE:    if (load) next_state = (src.s == '0) ? DONE : SHIFT;
                  else      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Control decode: load source, hold capture and drop decisions.
   always_comb begin
      load_hold = (state == DONE) && hold_valid;
      load_new  = endatain && ((state == IDLE) || ((state == DONE) && !hold_valid));
      load      = load_hold || load_new;
      src       = load_hold ? hold : cur;
      // In DONE the hold slot is vacated and refilled on the same edge.
      hold_cap  = endatain && (((state == SHIFT) && !hold_valid) || load_hold);
      drop      = endatain && (state == SHIFT) && hold_valid;
      busy      = (state != IDLE);
   end

   // Shifter, counter and output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr        <= '0;
         cnt       <= '0;
         shamt     <= '0;
         dataout   <= '0;
         dataready <= 1'b0;
      end else begin
         dataready <= (state == DONE);
         if (state == DONE) dataout <= sr;
         if (load) begin
            sr    <= src.v;
            shamt <= src.s;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            sr  <= sr << 1;
            cnt <= cnt + NQ_W'(1);
         end
      end
   end

   // Hold register and sticky overrun.
   // NOTE: the single hold entry is plain flops, so it is reset along with
   // its valid bit; a held sample must never survive a reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold       <= '0;
         hold_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (hold_cap) begin
            hold       <= cur;
            hold_valid <= 1'b1;
         end else if (load_hold) begin
            hold_valid <= 1'b0;
         end
         if (drop) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dequantize.sv
// Self-checking bench for dequantize: table-driven single samples plus
// hand-written hold/overrun, Nquant-change and async-reset sequences.
module tb_dequantize;

   logic        clock;
   logic        reset;
   logic [4:0]  Nquant;
   logic [17:0] datain;
   logic        endatain;
   logic [17:0] dataout;
   logic        dataready;
   logic        busy;
   logic        overrun;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [17:0] exp_q[$];

   typedef struct {
      logic [4:0]  nq;
      logic [17:0] din;
      logic [17:0] dout;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   dequantize dut (
      .clock     (clock),
      .reset     (reset),
      .Nquant    (Nquant),
      .datain    (datain),
      .endatain  (endatain),
      .dataout   (dataout),
      .dataready (dataready),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: integer sign-extension of the code, scaled by 2**S.
   function automatic logic [17:0] model(input logic [4:0] nq_in, input logic [17:0] din);
      int     nq, s;
      longint v;
      nq = (nq_in == 0 || nq_in > 18) ? 18 : int'(nq_in);
      s  = 18 - nq;
      v  = 0;
      for (int i = 0; i < nq; i++) if (din[i]) v += (longint'(1) << i);
      if (din[nq-1]) v -= (longint'(1) << nq);
      v = v * (longint'(1) << s);
      return v[17:0];
   endfunction

   // Scoreboard: every dataready pops one expected value.
   always @(negedge clock) begin
      if (!reset && dataready) begin
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("dataout", 32'(dataout), 32'(exp_q.pop_front()));
      end
   end

   task automatic run_one(input logic [4:0] nq, input logic [17:0] din,
                          input logic [17:0] dout, input int lat);
      int t0;
      bit seen;
      @(negedge clock);
      Nquant = nq; datain = din; endatain = 1'b1;
      exp_q.push_back(dout);
      @(negedge clock);
      endatain = 1'b0;
      t0 = cyc;
      check("busy_after_accept", 32'(busy), 32'd1);
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clock);
         if (dataready) begin
            seen = 1'b1;
            check("latency", 32'(cyc - t0), 32'(lat));
            check("busy_at_output", 32'(busy), 32'd0);
         end else begin
            check("busy_in_flight", 32'(busy), 32'd1);
         end
      end
      check("ready_seen", 32'(seen), 32'd1);
      @(negedge clock);
      check("ready_one_cycle", 32'(dataready), 32'd0);
   endtask

   initial begin
      int t0, n;
      int rdy[2];
      logic [17:0] d1, d2, d3, da, db;

      vecs[0]  = '{5'd8,  18'h3FF7F, 18'h1FC00, 11};
      vecs[1]  = '{5'd8,  18'h00080, 18'h20000, 11};
      vecs[2]  = '{5'd1,  18'h00001, 18'h20000, 18};
      vecs[3]  = '{5'd1,  18'h3FFFE, 18'h00000, 18};
      vecs[4]  = '{5'd18, 18'h2ABCD, 18'h2ABCD, 1};
      vecs[5]  = '{5'd0,  18'h2ABCD, 18'h2ABCD, 1};
      vecs[6]  = '{5'd25, 18'h2ABCD, 18'h2ABCD, 1};
      vecs[7]  = '{5'd4,  18'h00005, 18'h14000, 15};
      vecs[8]  = '{5'd17, 18'h1FFFF, 18'h3FFFE, 2};
      vecs[9]  = '{5'd31, 18'h12345, 18'h12345, 1};
      vecs[10] = '{5'd8,  18'h3FF80, 18'h20000, 11};

      reset = 1'b1; Nquant = '0; datain = '0; endatain = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_dataout",   32'(dataout),   32'd0);
      check("rst_dataready", 32'(dataready), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_overrun",   32'(overrun),   32'd0);
      reset = 1'b0;

      foreach (vecs[i]) run_one(vecs[i].nq, vecs[i].din, vecs[i].dout, vecs[i].lat);
      check("no_overrun_yet", 32'(overrun), 32'd0);

      // Three back-to-back samples at S=14: process, hold, drop.
      d1 = 18'h00009; d2 = 18'h00007; d3 = 18'h00003;
      @(negedge clock);
      Nquant = 5'd4; datain = d1; endatain = 1'b1; exp_q.push_back(model(5'd4, d1));
      @(negedge clock);
      t0 = cyc; datain = d2; exp_q.push_back(model(5'd4, d2));
      @(negedge clock);
      datain = d3;
      @(negedge clock);
      endatain = 1'b0;
      check("overrun_set", 32'(overrun), 32'd1);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (dataready) begin
            if (n < 2) rdy[n] = cyc - t0;
            n++;
         end
      end
      check("hold_outputs", 32'(n), 32'd2);
      check("hold_first_edge",  32'(rdy[0]), 32'd15);
      check("hold_second_edge", 32'(rdy[1]), 32'd30);
      check("overrun_sticky", 32'(overrun), 32'd1);

      // Nquant change mid-flight; held sample picks up the new width.
      da = 18'h00003; db = 18'h01234;
      @(negedge clock);
      Nquant = 5'd4; datain = da; endatain = 1'b1; exp_q.push_back(model(5'd4, da));
      @(negedge clock);
      t0 = cyc; endatain = 1'b0;
      @(negedge clock);
      @(negedge clock);
      Nquant = 5'd16;
      @(negedge clock);
      @(negedge clock);
      datain = db; endatain = 1'b1; exp_q.push_back(model(5'd16, db));
      @(negedge clock);
      endatain = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (dataready) begin
            if (n < 2) rdy[n] = cyc - t0;
            n++;
         end
      end
      check("nqchg_outputs", 32'(n), 32'd2);
      check("nqchg_first_edge",  32'(rdy[0]), 32'd15);
      check("nqchg_second_edge", 32'(rdy[1]), 32'd18);

      // Asynchronous reset mid-SHIFT with the hold slot full.
      @(negedge clock);
      Nquant = 5'd4; datain = 18'h00001; endatain = 1'b1;
      @(negedge clock);
      datain = 18'h00002;
      @(negedge clock);
      endatain = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check("arst_dataout",   32'(dataout),   32'd0);
      check("arst_dataready", 32'(dataready), 32'd0);
      check("arst_busy",      32'(busy),      32'd0);
      check("arst_overrun",   32'(overrun),   32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (dataready) n++;
      end
      check("no_ready_after_reset", 32'(n), 32'd0);
      run_one(5'd8, 18'h3FF7F, 18'h1FC00, 11);

      repeat (2) @(negedge clock);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
